tfc_seq: RTL

TFC_SEQ -- requirements
Module: tfc_seq

---
 rtl/tfc_pkg.sv | 19 +
 rtl/tfc_timer.sv | 47 ++++
 rtl/tfc_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tfc_pkg.sv
// tfc_pkg: shared definitions for the traffic-light sequencer.
//   - lamp colour codes, one 3-bit field per signal head: {red, yellow, green}
//   - phase_e: state encoding, also driven unchanged on the phase output
package tfc_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] OFF    = 3'b000;

    typedef enum logic [2:0] {
        ST_ALLRED  = 3'd0,
        ST_GREEN   = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_FLASH   = 3'd3,
        ST_PREEMPT = 3'd4
    } phase_e;

endpackage

// File: rtl/tfc_timer.sv
// tfc_timer: tick prescaler plus interval down-counter.
//   clk, rst : clock, asynchronous active-low reset
//   load     : restart the prescaler and latch a new interval from dur
//   dur      : interval length in ticks; 0 is treated as 1
//   tick     : one-clk pulse when the prescaler is at TICK_DIV-1
//   done     : tick that ends the last tick of the latched interval
module tfc_timer #(
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] dur,
    output logic             tick,
    output logic             done
);

    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]    presc;
    logic [CNT_W-1:0] remain;

    assign tick = (presc == PRESC_MAX);
    assign done = tick && (remain == CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc  <= '0;
            remain <= '0;
        end else if (load) begin
            presc  <= '0;
            remain <= (dur == '0) ? CNT_W'(1) : dur;
        end else if (tick) begin
            presc <= '0;
            if (remain != '0) begin
                remain <= remain - CNT_W'(1);
            end
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/tfc_seq.sv
// tfc_seq: multi-lane traffic signal sequencer with flashing and preemption.
//   clk, rst     : clock, asynchronous active-low reset
//   green_dur    : per-lane green time in ticks, lane i at [i*CNT_W +: CNT_W]
//   yellow_dur   : yellow clearance time in ticks
//   allred_dur   : all-red interval in ticks
//   flash_en     : night flashing-yellow request
//   preempt_req  : emergency preemption request (level)
//   preempt_lane : lane to serve on preemption
//   lights       : registered per-lane colour, lane i at [i*3 +: 3]
//   cur_lane     : registered lane currently or last served
//   phase        : registered state encoding (tfc_pkg::phase_e)
module tfc_seq
    import tfc_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 8,
    parameter int TICK_DIV  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LANES*CNT_W-1:0]   green_dur,
    input  logic [CNT_W-1:0]             yellow_dur,
    input  logic [CNT_W-1:0]             allred_dur,
    input  logic                         flash_en,
    input  logic                         preempt_req,
    input  logic [$clog2(NUM_LANES)-1:0] preempt_lane,
    output logic [NUM_LANES*3-1:0]       lights,
    output logic [$clog2(NUM_LANES)-1:0] cur_lane,
    output logic [2:0]                   phase
);

    localparam int               LW        = $clog2(NUM_LANES);
    localparam logic [LW-1:0]    LAST_LANE = LW'(NUM_LANES - 1);
    localparam logic [CNT_W-1:0] ONE_TICK  = CNT_W'(1);

    phase_e           state, state_n;
    logic [LW-1:0]    lane, lane_n;         // lane being / last served
    logic [LW-1:0]    plane, plane_n;       // preempt lane captured at sequence start
    logic             pend_pre, pend_pre_n; // preemption waiting behind yellow/all-red
    logic             pend_fl, pend_fl_n;   // flash waiting behind yellow/all-red
    logic             yel_all, yel_all_n;   // yellow shown on every head (leaving FLASH)
    logic             flash_on, flash_on_n;
    logic             armed, armed_n;       // low until the first post-reset edge

    logic             load, tick, done;
    logic [CNT_W-1:0] load_dur;

    logic             nxt_found;
    logic [LW-1:0]    nxt_lane, cand;
    logic [CNT_W-1:0] nxt_green;
    logic             pre_active;
    logic [LW-1:0]    sel_plane;
    logic [NUM_LANES*3-1:0] lights_c;

    function automatic logic [LW-1:0] wrap_add(input logic [LW-1:0] base, input int k);
        return LW'((int'(base) + k) % NUM_LANES);
    endfunction

    tfc_timer #(
        .CNT_W    (CNT_W),
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .dur  (load_dur),
        .tick (tick),
        .done (done)
    );

    // First lane after the current one with a non-zero green time; the
    // current lane itself is the last candidate, so a single active lane
    // is served repeatedly.
    always_comb begin
        nxt_found = 1'b0;
        nxt_lane  = lane;
        nxt_green = '0;
        cand      = lane;
        for (int k = 1; k <= NUM_LANES; k++) begin
            cand = wrap_add(lane, k);
            if (!nxt_found && green_dur[int'(cand)*CNT_W +: CNT_W] != '0) begin
                nxt_found = 1'b1;
                nxt_lane  = cand;
                nxt_green = green_dur[int'(cand)*CNT_W +: CNT_W];
            end
        end
    end

    always_comb begin
        // NOTE: every variable driven here is defaulted first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_n    = state;
        lane_n     = lane;
        plane_n    = plane;
        pend_pre_n = pend_pre;
        pend_fl_n  = pend_fl;
        yel_all_n  = yel_all;
        flash_on_n = flash_on;
        armed_n    = 1'b1;
        load       = 1'b0;
        load_dur   = allred_dur;
        pre_active = pend_pre | preempt_req;
        sel_plane  = pend_pre ? plane : preempt_lane;

        if (!armed) begin
            // The reset all-red interval starts on the first edge after release.
            load = 1'b1;
        end else begin
            case (state)
                ST_ALLRED: begin
                    if (done) begin
                        load = 1'b1;
                        if (pre_active) begin
                            state_n    = ST_PREEMPT;
                            lane_n     = sel_plane;
                            plane_n    = sel_plane;
                            pend_pre_n = 1'b0;
                            pend_fl_n  = 1'b0;
                            load_dur   = ONE_TICK;
                        end else if (pend_fl || flash_en) begin
                            state_n    = ST_FLASH;
                            flash_on_n = 1'b1;
                            pend_fl_n  = 1'b0;
                            load_dur   = ONE_TICK;
                        end else if (nxt_found) begin
                            state_n  = ST_GREEN;
                            lane_n   = nxt_lane;
                            load_dur = nxt_green;
                        end
                        // Otherwise every lane is idle: repeat the all-red interval.
                    end else begin
                        if (preempt_req && !pend_pre) begin
                            pend_pre_n = 1'b1;
                            plane_n    = preempt_lane;
                        end
                        if (flash_en) begin
                            pend_fl_n = 1'b1;
                        end
                    end
                end

                ST_GREEN: begin
                    if (preempt_req) begin
                        load      = 1'b1;
                        pend_fl_n = 1'b0;
                        plane_n   = preempt_lane;
                        if (preempt_lane == lane) begin
                            state_n  = ST_PREEMPT;
                            load_dur = ONE_TICK;
                        end else begin
                            state_n    = ST_YELLOW;
                            pend_pre_n = 1'b1;
                            load_dur   = yellow_dur;
                        end
                    end else if (flash_en || done) begin
                        state_n   = ST_YELLOW;
                        pend_fl_n = flash_en;
                        load      = 1'b1;
                        load_dur  = yellow_dur;
                    end
                end

                ST_YELLOW: begin
                    if (preempt_req && !pend_pre) begin
                        pend_pre_n = 1'b1;
                        plane_n    = preempt_lane;
                    end
                    if (flash_en) begin
                        pend_fl_n = 1'b1;
                    end
                    if (done) begin
                        state_n   = ST_ALLRED;
                        yel_all_n = 1'b0;
                        load      = 1'b1;
                        load_dur  = allred_dur;
                    end
                end

                ST_FLASH: begin
                    if (preempt_req) begin
                        state_n    = ST_YELLOW;
                        yel_all_n  = 1'b1;
                        pend_pre_n = 1'b1;
                        plane_n    = preempt_lane;
                        load       = 1'b1;
                        load_dur   = yellow_dur;
                    end else if (!flash_en) begin
                        // Leaving flash: park on the last lane so lane 0 is next.
                        state_n  = ST_ALLRED;
                        lane_n   = LAST_LANE;
                        load     = 1'b1;
                        load_dur = allred_dur;
                    end else if (tick) begin
                        flash_on_n = ~flash_on;
                    end
                end

                ST_PREEMPT: begin
                    if (!preempt_req) begin
                        state_n  = ST_YELLOW;
                        load     = 1'b1;
                        load_dur = yellow_dur;
                    end
                end

                default: begin
                    state_n = ST_ALLRED;
                    load    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_ALLRED;
            lane     <= LAST_LANE;
            plane    <= '0;
            pend_pre <= 1'b0;
            pend_fl  <= 1'b0;
            yel_all  <= 1'b0;
            flash_on <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_n;
            lane     <= lane_n;
            plane    <= plane_n;
            pend_pre <= pend_pre_n;
            pend_fl  <= pend_fl_n;
            yel_all  <= yel_all_n;
            flash_on <= flash_on_n;
            armed    <= armed_n;
        end
    end

    // Lamp pattern for the present state; registered below.
    always_comb begin
        lights_c = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            case (state)
                ST_GREEN, ST_PREEMPT:
                    lights_c[i*3 +: 3] = (int'(lane) == i) ? GREEN : RED;
                ST_YELLOW:
                    lights_c[i*3 +: 3] = (yel_all || int'(lane) == i) ? YELLOW : RED;
                ST_FLASH:
                    lights_c[i*3 +: 3] = flash_on ? YELLOW : OFF;
                default:
                    lights_c[i*3 +: 3] = RED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lights   <= {NUM_LANES{RED}};
            cur_lane <= LAST_LANE;
            phase    <= ST_ALLRED;
        end else begin
            lights   <= lights_c;
            cur_lane <= lane;
            phase    <= state;
        end
    end

endmodule
